// File: rtl/sparc_exu_addsub_arb.sv
// Two-requester arbiter/sequencer around a shared W-bit add/sub datapath.
// One issue entry drives the adder; results land in a depth-1 response buffer per requester.
module sparc_exu_addsub_arb #(
  parameter int unsigned W        = 64,
  parameter bit          PRIO_FIX = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_vld,
  output logic         req0_rdy,
  input  logic [W-1:0] req0_rs1,
  input  logic [W-1:0] req0_rs2,
  input  logic         req0_sub,
  input  logic         req0_cin,
  input  logic         req1_vld,
  output logic         req1_rdy,
  input  logic [W-1:0] req1_rs1,
  input  logic [W-1:0] req1_rs2,
  input  logic         req1_sub,
  input  logic         req1_cin,
  output logic [W-1:0] add_rs1,
  output logic [W-1:0] add_rs2,
  output logic         add_invert,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout64_l,
  input  logic         add_cout32,
  output logic         rsp0_vld,
  input  logic         rsp0_rdy,
  output logic [W-1:0] rsp0_sum,
  output logic         rsp0_c64,
  output logic         rsp0_c32,
  output logic         rsp0_v64,
  output logic         rsp0_v32,
  output logic         rsp1_vld,
  input  logic         rsp1_rdy,
  output logic [W-1:0] rsp1_sum,
  output logic         rsp1_c64,
  output logic         rsp1_c32,
  output logic         rsp1_v64,
  output logic         rsp1_v32
);

  typedef struct packed {
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic         sub;
    logic         cin;
    logic         tag;
  } iss_t;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c64;
    logic         c32;
    logic         v64;
    logic         v32;
  } rsp_t;

  logic       iss_vld;
  iss_t       iss_q;
  logic       last;
  logic [1:0] rsp_vld;
  rsp_t       rsp_q [2];

  logic       e_hi, e_31;
  rsp_t       res_c;
  logic [1:0] pop_c;
  logic       adv_c;
  logic       free_c;
  logic       grant_c;
  logic       acc_c;
  iss_t       new_c;

  // Result capture: sign of effective operand 2 decides signed overflow.
  always_comb begin
    e_hi      = iss_q.rs2[W-1] ^ iss_q.sub;
    e_31      = iss_q.rs2[31] ^ iss_q.sub;
    res_c.sum = add_sum;
    res_c.c64 = ~add_cout64_l;
    res_c.c32 = add_cout32;
    res_c.v64 = (iss_q.rs1[W-1] == e_hi) & (add_sum[W-1] != iss_q.rs1[W-1]);
    res_c.v32 = (iss_q.rs1[31] == e_31) & (add_sum[31] != iss_q.rs1[31]);
  end

  always_comb begin
    pop_c  = rsp_vld & {rsp1_rdy, rsp0_rdy};
    adv_c  = iss_vld & (~rsp_vld[iss_q.tag] | pop_c[iss_q.tag]);
    free_c = ~iss_vld | adv_c;
  end

  // Grant: a lone valid requester wins; ties go by priority mode.
  always_comb begin
    grant_c = 1'b0;
    if (req0_vld && req1_vld) begin
      grant_c = PRIO_FIX ? 1'b0 : ~last;
    end else if (req1_vld) begin
      grant_c = 1'b1;
    end else if (!req0_vld) begin
      grant_c = PRIO_FIX ? 1'b0 : ~last;
    end
  end

  always_comb begin
    req0_rdy = free_c & ~grant_c & ~rst;
    req1_rdy = free_c & grant_c & ~rst;
    acc_c    = (req0_vld & req0_rdy) | (req1_vld & req1_rdy);
    new_c    = grant_c ? {req1_rs1, req1_rs2, req1_sub, req1_cin, 1'b1}
                       : {req0_rs1, req0_rs2, req0_sub, req0_cin, 1'b0};
  end

  // Issue stage; payload is cleared when it empties so the adder sees zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld <= 1'b0;
      iss_q   <= '0;
      last    <= 1'b1;
    end else if (acc_c) begin
      iss_vld <= 1'b1;
      iss_q   <= new_c;
      last    <= grant_c;
    end else if (adv_c) begin
      iss_vld <= 1'b0;
      iss_q   <= '0;
    end
  end

  // Response buffers: refill has precedence over pop.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        rsp_vld[n] <= 1'b0;
        rsp_q[n]   <= '0;
      end else if (adv_c && (iss_q.tag == 1'(n))) begin
        rsp_vld[n] <= 1'b1;
        rsp_q[n]   <= res_c;
      end else if (pop_c[n]) begin
        rsp_vld[n] <= 1'b0;
      end
    end
  end

  assign add_rs1    = iss_q.rs1;
  assign add_rs2    = iss_q.rs2;
  assign add_invert = iss_q.sub;
  assign add_cin    = iss_q.cin;

  assign rsp0_vld = rsp_vld[0];
  assign rsp0_sum = rsp_q[0].sum;
  assign rsp0_c64 = rsp_q[0].c64;
  assign rsp0_c32 = rsp_q[0].c32;
  assign rsp0_v64 = rsp_q[0].v64;
  assign rsp0_v32 = rsp_q[0].v32;
  assign rsp1_vld = rsp_vld[1];
  assign rsp1_sum = rsp_q[1].sum;
  assign rsp1_c64 = rsp_q[1].c64;
  assign rsp1_c32 = rsp_q[1].c32;
  assign rsp1_v64 = rsp_q[1].v64;
  assign rsp1_v32 = rsp_q[1].v32;

endmodule

// File: tb/tb_sparc_exu_addsub_arb.sv
// Bench for sparc_exu_addsub_arb: behavioural adder, queue scoreboard and scenario tasks.
module tb_sparc_exu_addsub_arb;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_vld = 1'b0, req1_vld = 1'b0;
  logic         req0_rdy, req1_rdy;
  logic [W-1:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
  logic         req0_sub = 1'b0, req0_cin = 1'b0, req1_sub = 1'b0, req1_cin = 1'b0;
  logic [W-1:0] add_rs1, add_rs2, add_sum;
  logic         add_invert, add_cin, add_cout64_l, add_cout32;
  logic         rsp0_vld, rsp1_vld;
  logic         rsp0_rdy = 1'b1, rsp1_rdy = 1'b1;
  logic [W-1:0] rsp0_sum, rsp1_sum;
  logic         rsp0_c64, rsp0_c32, rsp0_v64, rsp0_v32;
  logic         rsp1_c64, rsp1_c32, rsp1_v64, rsp1_v32;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pops0 = 0;
  int pops1 = 0;
  bit chk_lat = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sparc_exu_addsub_arb #(.W(W), .PRIO_FIX(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req0_sub(req0_sub), .req0_cin(req0_cin),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .req1_sub(req1_sub), .req1_cin(req1_cin),
    .add_rs1(add_rs1), .add_rs2(add_rs2), .add_invert(add_invert), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout64_l(add_cout64_l), .add_cout32(add_cout32),
    .rsp0_vld(rsp0_vld), .rsp0_rdy(rsp0_rdy), .rsp0_sum(rsp0_sum), .rsp0_c64(rsp0_c64),
    .rsp0_c32(rsp0_c32), .rsp0_v64(rsp0_v64), .rsp0_v32(rsp0_v32),
    .rsp1_vld(rsp1_vld), .rsp1_rdy(rsp1_rdy), .rsp1_sum(rsp1_sum), .rsp1_c64(rsp1_c64),
    .rsp1_c32(rsp1_c32), .rsp1_v64(rsp1_v64), .rsp1_v32(rsp1_v32)
  );

  // Shared adder modelled as plain wide addition.
  logic [W-1:0] add_e;
  logic [W:0]   add_full;
  logic [32:0]  add_lo;
  assign add_e        = add_invert ? ~add_rs2 : add_rs2;
  assign add_full     = {1'b0, add_rs1} + {1'b0, add_e} + (W+1)'(add_cin);
  assign add_lo       = {1'b0, add_rs1[31:0]} + {1'b0, add_e[31:0]} + 33'(add_cin);
  assign add_sum      = add_full[W-1:0];
  assign add_cout64_l = ~add_full[W];
  assign add_cout32   = add_lo[32];

  // Reference: carries from wide sums, overflow as carry-into-msb xor carry-out.
  function automatic logic [W+3:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s, input logic c);
    logic [W-1:0] e;
    logic [W:0]   f;
    logic [W-1:0] m;
    logic [32:0]  lo;
    logic [31:0]  m31;
    e   = s ? ~b : b;
    f   = {1'b0, a} + {1'b0, e} + (W+1)'(c);
    m   = {1'b0, a[W-2:0]} + {1'b0, e[W-2:0]} + W'(c);
    lo  = {1'b0, a[31:0]} + {1'b0, e[31:0]} + 33'(c);
    m31 = {1'b0, a[30:0]} + {1'b0, e[30:0]} + 32'(c);
    return {f[W-1:0], f[W], lo[32], m[W-1] ^ f[W], m31[31] ^ lo[32]};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      4: v = W'(32'h7FFF_FFFF);
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  typedef struct {
    logic [W+3:0] res;
    int           cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Scoreboard: each accept enqueues its expected result; each pop is checked in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (rsp0_vld && rsp0_rdy) begin
        pops0++;
        n_cmp++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL sb_rsp0_unexpected: got sum=%h with no accepted op", rsp0_sum);
        end else begin
          e = q0.pop_front();
          if ({rsp0_sum, rsp0_c64, rsp0_c32, rsp0_v64, rsp0_v32} !== e.res) begin
            n_err++;
            $display("FAIL sb_rsp0_data: got %h expected %h",
                     {rsp0_sum, rsp0_c64, rsp0_c32, rsp0_v64, rsp0_v32}, e.res);
          end
          if (chk_lat) begin
            n_cmp++;
            if (cyc - e.cyc !== 2) begin
              n_err++;
              $display("FAIL sb_rsp0_latency: got %0d expected 2", cyc - e.cyc);
            end
          end
        end
      end
      if (rsp1_vld && rsp1_rdy) begin
        pops1++;
        n_cmp++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL sb_rsp1_unexpected: got sum=%h with no accepted op", rsp1_sum);
        end else begin
          e = q1.pop_front();
          if ({rsp1_sum, rsp1_c64, rsp1_c32, rsp1_v64, rsp1_v32} !== e.res) begin
            n_err++;
            $display("FAIL sb_rsp1_data: got %h expected %h",
                     {rsp1_sum, rsp1_c64, rsp1_c32, rsp1_v64, rsp1_v32}, e.res);
          end
          if (chk_lat) begin
            n_cmp++;
            if (cyc - e.cyc !== 2) begin
              n_err++;
              $display("FAIL sb_rsp1_latency: got %0d expected 2", cyc - e.cyc);
            end
          end
        end
      end
      if (req0_vld && req0_rdy) q0.push_back('{ref_calc(req0_rs1, req0_rs2, req0_sub, req0_cin), cyc});
      if (req1_vld && req1_rdy) q1.push_back('{ref_calc(req1_rs1, req1_rs2, req1_sub, req1_cin), cyc});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    rsp0_rdy = 1'b1;
    rsp1_rdy = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Drives one op on requester n and returns the first visible response and its latency.
  task automatic run_one(input bit n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c, output logic [W+3:0] got,
                         output int lat, output logic oth, output bit ok);
    int t0;
    bit acc;
    ok = 1'b0; acc = 1'b0; got = '0; lat = 0; oth = 1'b0; t0 = 0;
    if (n) begin
      req1_rs1 = a; req1_rs2 = b; req1_sub = s; req1_cin = c; req1_vld = 1'b1;
    end else begin
      req0_rs1 = a; req0_rs2 = b; req0_sub = s; req0_cin = c; req0_vld = 1'b1;
    end
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (n ? req1_rdy : req0_rdy) begin
        acc = 1'b1;
        t0 = cyc;
      end
      next_cycle();
    end
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    if (!acc) return;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n ? rsp1_vld : rsp0_vld) begin
        got = n ? {rsp1_sum, rsp1_c64, rsp1_c32, rsp1_v64, rsp1_v32}
                : {rsp0_sum, rsp0_c64, rsp0_c32, rsp0_v64, rsp0_v32};
        oth = n ? rsp0_vld : rsp1_vld;
        lat = cyc - t0;
        ok = 1'b1;
        break;
      end
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req0_rdy, req1_rdy, rsp0_vld, rsp1_vld} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_handshake: got %b expected 0000", {req0_rdy, req1_rdy, rsp0_vld, rsp1_vld});
    end
    n_cmp++;
    if ({rsp0_sum, rsp1_sum, add_rs1, add_rs2, add_invert, add_cin} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rsp0_sum=%h rsp1_sum=%h add_rs1=%h expected all zero",
               rsp0_sum, rsp1_sum, add_rs1);
    end
    next_cycle();
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [W+3:0] got;
    int lat;
    logic oth;
    bit ok;
    do_reset();
    run_one(1'b0, W'(5), W'(3), 1'b1, 1'b1, got, lat, oth, ok);
    n_cmp++;
    if (!ok || got !== {W'(2), 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL single_sub: ok=%0d got %h expected %h", ok, got, {W'(2), 4'b1100});
    end
    n_cmp++;
    if (lat !== 2 || oth !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency: got lat=%0d rsp1_vld=%b expected 2 and 0", lat, oth);
    end
  endtask

  task automatic test_arith();
    logic [W+3:0] got;
    int lat;
    logic oth;
    bit ok;
    logic [W-1:0] ones;
    logic [W-1:0] maxpos;
    ones = '1;
    maxpos = {1'b0, {(W-1){1'b1}}};
    run_one(1'b0, maxpos, W'(1), 1'b0, 1'b0, got, lat, oth, ok);
    n_cmp++;
    if (!ok || got !== {{1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL overflow64: ok=%0d got %h expected sum=8000.. c64=0 c32=1 v64=1 v32=0", ok, got);
    end
    run_one(1'b1, W'(32'h7FFF_FFFF), W'(1), 1'b0, 1'b0, got, lat, oth, ok);
    n_cmp++;
    if (!ok || got !== {W'(32'h8000_0000), 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL overflow32: ok=%0d got %h expected sum=80000000 v32=1 only", ok, got);
    end
    run_one(1'b0, ones, W'(1), 1'b0, 1'b0, got, lat, oth, ok);
    n_cmp++;
    if (!ok || got !== {W'(0), 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL carry_wrap: ok=%0d got %h expected sum=0 c64=1 c32=1 v=0", ok, got);
    end
    run_one(1'b1, W'(3), W'(5), 1'b1, 1'b1, got, lat, oth, ok);
    n_cmp++;
    if (!ok || got !== {ones - W'(1), 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL borrow: ok=%0d got %h expected sum=-2 no carries", ok, got);
    end
  endtask

  task automatic test_contention();
    bit exp_g;
    do_reset();
    chk_lat = 1'b1;
    exp_g = 1'b0;
    req0_vld = 1'b1; req1_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req0_rs1 = pick_operand(); req0_rs2 = pick_operand();
      req0_sub = 1'($urandom); req0_cin = 1'($urandom);
      req1_rs1 = pick_operand(); req1_rs2 = pick_operand();
      req1_sub = 1'($urandom); req1_cin = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({req0_rdy, req1_rdy} !== {~exp_g, exp_g}) begin
        n_err++;
        $display("FAIL contention_grant[%0d]: got rdy=%b%b expected %b%b",
                 i, req0_rdy, req1_rdy, ~exp_g, exp_g);
      end
      next_cycle();
      exp_g = ~exp_g;
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    repeat (4) next_cycle();
    chk_lat = 1'b0;
    n_cmp++;
    if (q0.size() + q1.size() !== 0) begin
      n_err++;
      $display("FAIL contention_drain: got %0d outstanding expected 0", q0.size() + q1.size());
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] op2_rs1;
    bit acc0;
    int p0;
    do_reset();
    p0 = pops0;
    rsp0_rdy = 1'b0;
    op2_rs1 = '0;
    req0_vld = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req0_rs1 = {$urandom, $urandom}; req0_rs2 = {$urandom, $urandom};
      req0_sub = 1'($urandom); req0_cin = 1'($urandom);
      op2_rs1 = req0_rs1;
      @(negedge clk);
      n_cmp++;
      if (req0_rdy !== 1'b1) begin
        n_err++;
        $display("FAIL bp_accept[%0d]: got req0_rdy=%b expected 1", k, req0_rdy);
      end
      next_cycle();
    end
    req0_rs1 = {$urandom, $urandom}; req0_rs2 = {$urandom, $urandom};
    req1_vld = 1'b1;
    req1_rs1 = {$urandom, $urandom}; req1_rs2 = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({req0_rdy, req1_rdy, rsp0_vld} !== 3'b001 || add_rs1 !== op2_rs1) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got rdy=%b%b rsp0_vld=%b add_rs1=%h expected 00 1 %h",
                 i, req0_rdy, req1_rdy, rsp0_vld, add_rs1, op2_rs1);
      end
      next_cycle();
    end
    rsp0_rdy = 1'b1;
    acc0 = 1'b0;
    for (int i = 0; i < 20 && !acc0; i++) begin
      @(negedge clk);
      acc0 = req0_rdy;
      next_cycle();
      if (acc0) req0_vld = 1'b0;
      req1_rs1 = {$urandom, $urandom};
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    n_cmp++;
    if (!acc0) begin
      n_err++;
      $display("FAIL bp_release: got no accept of op3 expected accept within 20 cycles");
    end
    repeat (5) next_cycle();
    n_cmp++;
    if (pops0 - p0 !== 3 || q0.size() !== 0) begin
      n_err++;
      $display("FAIL bp_delivery: got %0d rsp0 pops, %0d pending expected 3 and 0",
               pops0 - p0, q0.size());
    end
  endtask

  task automatic test_random();
    bit a0, a1;
    a0 = 1'b1; a1 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (a0) begin
        req0_vld = 1'($urandom_range(0, 3) != 0);
        req0_rs1 = pick_operand(); req0_rs2 = pick_operand();
        req0_sub = 1'($urandom); req0_cin = 1'($urandom);
      end
      if (a1) begin
        req1_vld = 1'($urandom_range(0, 3) != 0);
        req1_rs1 = pick_operand(); req1_rs2 = pick_operand();
        req1_sub = 1'($urandom); req1_cin = 1'($urandom);
      end
      rsp0_rdy = 1'($urandom_range(0, 2) != 0);
      rsp1_rdy = 1'($urandom_range(0, 2) != 0);
      @(negedge clk);
      a0 = !req0_vld || req0_rdy;
      a1 = !req1_vld || req1_rdy;
      next_cycle();
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;
    repeat (6) next_cycle();
    n_cmp++;
    if (q0.size() !== 0 || q1.size() !== 0) begin
      n_err++;
      $display("FAIL random_drain: got %0d/%0d outstanding expected 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] op2_rs1;
    do_reset();
    rsp1_rdy = 1'b0;
    op2_rs1 = '0;
    req1_vld = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req1_rs1 = {$urandom, $urandom}; req1_rs2 = {$urandom, $urandom};
      op2_rs1 = req1_rs1;
      @(negedge clk);
      n_cmp++;
      if (req1_rdy !== 1'b1 || req0_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_fill[%0d]: got rdy=%b%b expected 01", k, req0_rdy, req1_rdy);
      end
      next_cycle();
    end
    req1_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp1_vld !== 1'b1 || add_rs1 !== op2_rs1) begin
      n_err++;
      $display("FAIL midrst_full: got rsp1_vld=%b add_rs1=%h expected 1 %h", rsp1_vld, add_rs1, op2_rs1);
    end
    next_cycle();
    rst = 1'b1;
    req0_vld = 1'b1; req1_vld = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req0_rdy, req1_rdy} !== 2'b00) begin
      n_err++;
      $display("FAIL midrst_rdy: got %b%b expected 00", req0_rdy, req1_rdy);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({rsp0_vld, rsp1_vld} !== 2'b00 || add_rs1 !== '0 || rsp1_sum !== '0) begin
      n_err++;
      $display("FAIL midrst_flush: got vld=%b%b add_rs1=%h rsp1_sum=%h expected 00 0 0",
               rsp0_vld, rsp1_vld, add_rs1, rsp1_sum);
    end
    next_cycle();
    rst = 1'b0;
    rsp1_rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req0_rdy, req1_rdy} !== 2'b10) begin
      n_err++;
      $display("FAIL midrst_tie: got %b%b expected 10", req0_rdy, req1_rdy);
    end
    next_cycle();
    req0_vld = 1'b0; req1_vld = 1'b0;
    repeat (5) next_cycle();
    n_cmp++;
    if (q0.size() !== 0 || q1.size() !== 0) begin
      n_err++;
      $display("FAIL midrst_drain: got %0d/%0d outstanding expected 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arith();
    test_contention();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sparc_exu_addsub_arb.md
Name: sparc_exu_addsub_arb

Overview:
Arbiter and sequencer that shares one 64-bit add/sub datapath between two requesters, e.g. the integer ALU issue path and the address-generation path. It accepts operations over valid/ready handshakes and registers the selected operands into an issue stage. It drives the shared adder from that stage, then captures sum, carries and overflow into one response buffer per requester. Fixed latency is 2 cycles from accept to response valid, with full backpressure.

Parameters:
W, 64, datapath width; even, >= 8; the 32-bit flags use bit 31, so W >= 32 when v32/c32 are used.
PRIO_FIX, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.

Ports:
clk  in  1  clock
rst  in  1  reset
reqN_vld  in  1  request valid (N = 0,1)
reqN_rdy  out  1  request accepted when vld & rdy
reqN_rs1  in  W  operand 1
reqN_rs2  in  W  operand 2, un-inverted
reqN_sub  in  1  1 = subtract (rs2 inverted)
reqN_cin  in  1  carry in
add_rs1  out  W  to shared adder, operand 1
add_rs2  out  W  to shared adder, raw operand 2
add_invert  out  1  to shared adder, invert rs2
add_cin  out  1  to shared adder, carry in
add_sum  in  W  adder result, combinational from add_*
add_cout64_l  in  1  adder carry-out of bit W-1, active low
add_cout32  in  1  adder carry-out of bit 31
rspN_vld  out  1  response valid
rspN_rdy  in  1  response consumed when vld & rdy
rspN_sum  out  W  result
rspN_c64  out  1  carry-out, active high
rspN_c32  out  1  carry-out of bit 31
rspN_v64  out  1  signed overflow, full width
rspN_v32  out  1  signed overflow, low 32 bits

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-high.
- Reset behaviour: while rst=1, and on the first edge after it:
  - issue stage empty; rspN_vld=0; rspN_sum/flags=0.
  - reqN_rdy forced 0.
  - round-robin pointer last=1, so requester 0 wins first.
  - Reset mid-operation discards in-flight and buffered ops without a response.
- Issue stage: single entry holding {rs1, rs2, sub, cin, tag}.
  - When empty, add_* outputs are driven 0.
  - Otherwise add_rs1=rs1, add_rs2=rs2, add_invert=sub, add_cin=cin.
- Advance: the issue stage moves to response buffer [tag] at the clock edge when that buffer is empty or is popped in the same cycle.
  - The captured result is add_sum, c64=~add_cout64_l, c32=add_cout32.
  - With e = rs2 ^ {W{sub}}: v64 = (rs1[W-1]==e[W-1]) & (sum[W-1]!=rs1[W-1]).
  - v32 is the same formula on bit 31.
- Accept: free = issue empty | advancing this cycle.
- Grant (combinational, evaluated when free=1):
  - One requester valid: grant it.
  - Both valid with PRIO_FIX=0: grant ~last.
  - Both valid with PRIO_FIX=1: grant 0.
  - reqN_rdy = free & grant==N & ~rst. reqN_rdy does not depend on reqN_vld for the non-competing case; if only one requester is valid, only that requester's rdy may be 1.
  - last updates to the granted index only on an actual accept.
- Latency: accept at edge T, issue stage valid after T, response valid after edge T+1. Throughput is 1 op/cycle when responses drain.
- Head-of-line: an issue entry blocked on a full rspN buffer stalls both requesters. This is intended, and requesters must not make rspN_rdy depend on reqN_rdy.
- Response buffer: depth 1 per requester.
  - Holds value and vld until rspN_rdy.
  - Pop and refill in the same cycle is allowed and the buffer stays valid with new data.
- Arithmetic: modulo 2^W. Carries are unsigned carry-outs, so subtract with cin=1 and no borrow gives c64=1.
- Simultaneous events: pop of rsp0 together with arrival of an issue entry tagged 0 resolves as a refill. A new accept in the same cycle is allowed.

Test Plan:
1. Single op: req0 rs1=5, rs2=3, sub=1, cin=1 accepted at T -> rsp0_vld at T+2 with sum=2, c64=1, v64=0; rsp1_vld stays 0.
2. Contention: both vld from the first cycle after reset, rsp_rdy=1 -> grants 0,1,0,1…; each response arrives 2 cycles after its accept with correct per-requester sums. With PRIO_FIX=1 -> only req0 is granted while it stays valid.
3. Backpressure: rsp0_rdy=0, req0 issues 3 ops:
   - op1 is buffered and op2 is held in the issue stage.
   - req1 and req0 both see rdy=0.
   - Raise rsp0_rdy -> ops are delivered in order, none lost or duplicated.
4. Overflow: rs1=0x7FFF_FFFF_FFFF_FFFF + rs2=1, cin=0 -> sum=0x8000_0000_0000_0000, v64=1, c64=0. rs1=0x7FFF_FFFF + 1 -> v32=1, c32=0.
5. Carry: rs1=0xFFFF_FFFF_FFFF_FFFF + 1 -> sum=0, c64=1, c32=1, v64=0.
6. Reset mid-flight: assert rst with the issue stage and rsp1 full -> next cycle all rspN_vld=0, reqN_rdy=0. After rst drops, req0 wins a tie.
